rs_scheduler: RTL and testbench

RS_SCHEDULER -- requirements
Module: rs_scheduler

---
 rtl/rs_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_rs_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_scheduler.sv
// Reservation station: holds issued ops until both operands are resolved by ALU/load
// broadcasts, then dispatches the lowest-index ready entry to the ALU, one per cycle.
module rs_scheduler #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned OP_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             issue_en,
  input  logic [OP_W-1:0]  issue_openum,
  input  logic [31:0]      issue_rs1_val,
  input  logic [31:0]      issue_rs2_val,
  input  logic [TAG_W-1:0] issue_rs1_rob_pos,
  input  logic [TAG_W-1:0] issue_rs2_rob_pos,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_pc,
  input  logic [TAG_W-1:0] issue_rob_pos,
  input  logic             alu_result_ready,
  input  logic [TAG_W-1:0] alu_result_rob_pos,
  input  logic [31:0]      alu_result_val,
  input  logic             lsb_load_result_ready,
  input  logic [TAG_W-1:0] lsb_load_result_rob_pos,
  input  logic [31:0]      lsb_load_result_val,
  output logic             rs_full,
  output logic             alu_en,
  output logic [OP_W-1:0]  alu_openum,
  output logic [31:0]      alu_rs1_val,
  output logic [31:0]      alu_rs2_val,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [TAG_W-1:0] alu_rob_pos
);

  localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int unsigned CntW = $clog2(RS_SIZE + 1);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [OP_W-1:0]    op_d  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        vj_d  [RS_SIZE];
  logic [31:0]        vk_q  [RS_SIZE];
  logic [31:0]        vk_d  [RS_SIZE];
  logic [TAG_W-1:0]   qj_q  [RS_SIZE];
  logic [TAG_W-1:0]   qj_d  [RS_SIZE];
  logic [TAG_W-1:0]   qk_q  [RS_SIZE];
  logic [TAG_W-1:0]   qk_d  [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];
  logic [31:0]        imm_d [RS_SIZE];
  logic [31:0]        pc_q  [RS_SIZE];
  logic [31:0]        pc_d  [RS_SIZE];
  logic [TAG_W-1:0]   rob_q [RS_SIZE];
  logic [TAG_W-1:0]   rob_d [RS_SIZE];

  logic             alu_en_q, alu_en_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [31:0]      alu_rs1_q, alu_rs1_d;
  logic [31:0]      alu_rs2_q, alu_rs2_d;
  logic [31:0]      alu_imm_q, alu_imm_d;
  logic [31:0]      alu_pc_q, alu_pc_d;
  logic [TAG_W-1:0] alu_rob_q, alu_rob_d;

  logic            sel_found, free_found;
  logic [IdxW-1:0] sel_idx, free_idx;
  logic [CntW-1:0] free_cnt;

  logic [31:0]      iss_vj, iss_vk;
  logic [TAG_W-1:0] iss_qj, iss_qk;

  // Selection, free-slot search and occupancy all look at pre-edge state only.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    free_cnt   = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (!sel_found && busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (!busy_q[i]) begin
        free_cnt = free_cnt + CntW'(1);
      end
    end
  end

  assign rs_full = (free_cnt <= CntW'(1));

  // Same-cycle broadcast forwarding for the operands being inserted.
  always_comb begin
    iss_vj = issue_rs1_val;
    iss_qj = issue_rs1_rob_pos;
    iss_vk = issue_rs2_val;
    iss_qk = issue_rs2_rob_pos;
    if (issue_rs1_rob_pos != '0) begin
      if (alu_result_ready && (alu_result_rob_pos == issue_rs1_rob_pos)) begin
        iss_vj = alu_result_val;
        iss_qj = '0;
      end else if (lsb_load_result_ready && (lsb_load_result_rob_pos == issue_rs1_rob_pos)) begin
        iss_vj = lsb_load_result_val;
        iss_qj = '0;
      end
    end
    if (issue_rs2_rob_pos != '0) begin
      if (alu_result_ready && (alu_result_rob_pos == issue_rs2_rob_pos)) begin
        iss_vk = alu_result_val;
        iss_qk = '0;
      end else if (lsb_load_result_ready && (lsb_load_result_rob_pos == issue_rs2_rob_pos)) begin
        iss_vk = lsb_load_result_val;
        iss_qk = '0;
      end
    end
  end

  always_comb begin
    busy_d    = busy_q;
    op_d      = op_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    rob_d     = rob_q;
    alu_en_d  = 1'b0;
    alu_op_d  = alu_op_q;
    alu_rs1_d = alu_rs1_q;
    alu_rs2_d = alu_rs2_q;
    alu_imm_d = alu_imm_q;
    alu_pc_d  = alu_pc_q;
    alu_rob_d = alu_rob_q;

    if (clr) begin
      busy_d = '0;
    end else if (rdy) begin
      if (sel_found) begin
        alu_en_d         = 1'b1;
        alu_op_d         = op_q[sel_idx];
        alu_rs1_d        = vj_q[sel_idx];
        alu_rs2_d        = vk_q[sel_idx];
        alu_imm_d        = imm_q[sel_idx];
        alu_pc_d         = pc_q[sel_idx];
        alu_rob_d        = rob_q[sel_idx];
        busy_d[sel_idx]  = 1'b0;
      end

      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (busy_q[i] && (qj_q[i] != '0)) begin
          if (alu_result_ready && (alu_result_rob_pos == qj_q[i])) begin
            vj_d[i] = alu_result_val;
            qj_d[i] = '0;
          end else if (lsb_load_result_ready && (lsb_load_result_rob_pos == qj_q[i])) begin
            vj_d[i] = lsb_load_result_val;
            qj_d[i] = '0;
          end
        end
        if (busy_q[i] && (qk_q[i] != '0)) begin
          if (alu_result_ready && (alu_result_rob_pos == qk_q[i])) begin
            vk_d[i] = alu_result_val;
            qk_d[i] = '0;
          end else if (lsb_load_result_ready && (lsb_load_result_rob_pos == qk_q[i])) begin
            vk_d[i] = lsb_load_result_val;
            qk_d[i] = '0;
          end
        end
      end

      // free_idx is never the selected entry, so a slot freed this edge stays empty.
      if (issue_en && free_found) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = issue_openum;
        vj_d[free_idx]   = iss_vj;
        qj_d[free_idx]   = iss_qj;
        vk_d[free_idx]   = iss_vk;
        qk_d[free_idx]   = iss_qk;
        imm_d[free_idx]  = issue_imm;
        pc_d[free_idx]   = issue_pc;
        rob_d[free_idx]  = issue_rob_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q    <= '0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0;
      alu_rs1_q <= '0;
      alu_rs2_q <= '0;
      alu_imm_q <= '0;
      alu_pc_q  <= '0;
      alu_rob_q <= '0;
    end else begin
      busy_q    <= busy_d;
      alu_en_q  <= alu_en_d;
      alu_op_q  <= alu_op_d;
      alu_rs1_q <= alu_rs1_d;
      alu_rs2_q <= alu_rs2_d;
      alu_imm_q <= alu_imm_d;
      alu_pc_q  <= alu_pc_d;
      alu_rob_q <= alu_rob_d;
    end
  end

  // Entry payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    imm_q <= imm_d;
    pc_q  <= pc_d;
    rob_q <= rob_d;
  end

  assign alu_en      = alu_en_q;
  assign alu_openum  = alu_op_q;
  assign alu_rs1_val = alu_rs1_q;
  assign alu_rs2_val = alu_rs2_q;
  assign alu_imm     = alu_imm_q;
  assign alu_pc      = alu_pc_q;
  assign alu_rob_pos = alu_rob_q;

endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: directed scenarios plus a randomized run checked against an
// entry-list reference model that advances one clock edge at a time.
module tb_rs_scheduler;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, issue_en;
  logic [5:0]  issue_openum;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
  logic [4:0]  issue_rs1_rob_pos, issue_rs2_rob_pos, issue_rob_pos;
  logic        alu_result_ready, lsb_load_result_ready;
  logic [4:0]  alu_result_rob_pos, lsb_load_result_rob_pos;
  logic [31:0] alu_result_val, lsb_load_result_val;
  logic        rs_full, alu_en;
  logic [5:0]  alu_openum;
  logic [31:0] alu_rs1_val, alu_rs2_val, alu_imm, alu_pc;
  logic [4:0]  alu_rob_pos;

  int n_cmp = 0;
  int n_fail = 0;

  rs_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .issue_en(issue_en),
    .issue_openum(issue_openum), .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_rob_pos(issue_rs1_rob_pos), .issue_rs2_rob_pos(issue_rs2_rob_pos),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos),
    .alu_result_ready(alu_result_ready), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val), .lsb_load_result_ready(lsb_load_result_ready),
    .lsb_load_result_rob_pos(lsb_load_result_rob_pos),
    .lsb_load_result_val(lsb_load_result_val), .rs_full(rs_full), .alu_en(alu_en),
    .alu_openum(alu_openum), .alu_rs1_val(alu_rs1_val), .alu_rs2_val(alu_rs2_val),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  // Reference model: a list of waiting ops, each with operand tag/value pairs.
  typedef struct {
    bit        busy;
    bit [5:0]  op;
    bit [31:0] vj, vk, imm, pc;
    bit [4:0]  qj, qk, rob;
  } ent_t;

  ent_t       mdl[8];
  bit         m_en;
  bit [5:0]   m_op;
  bit [31:0]  m_rs1, m_rs2, m_imm, m_pc;
  bit [4:0]   m_rob;

  // An operand waiting on tag becomes the broadcast value if that tag is on a bus now.
  function automatic void resolve(input bit [4:0] tag, input bit [31:0] val,
                                  output bit [4:0] q_o, output bit [31:0] v_o);
    q_o = tag;
    v_o = val;
    if (tag != 0) begin
      if (alu_result_ready && alu_result_rob_pos == tag) begin
        q_o = 0; v_o = alu_result_val;
      end else if (lsb_load_result_ready && lsb_load_result_rob_pos == tag) begin
        q_o = 0; v_o = lsb_load_result_val;
      end
    end
  endfunction

  function automatic int model_free();
    int n = 0;
    foreach (mdl[i]) if (!mdl[i].busy) n++;
    return n;
  endfunction

  function automatic void model_step();
    ent_t nxt[8];
    int   ready_l[$];
    int   free_l[$];
    if (!rst) begin
      foreach (mdl[i]) mdl[i].busy = 0;
      m_en = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0; m_rob = 0;
      return;
    end
    m_en = 0;
    if (clr) begin
      foreach (mdl[i]) mdl[i].busy = 0;
      return;
    end
    if (!rdy) return;
    nxt = mdl;
    foreach (mdl[i]) begin
      if (mdl[i].busy && mdl[i].qj == 0 && mdl[i].qk == 0) ready_l.push_back(i);
      if (!mdl[i].busy) free_l.push_back(i);
      if (mdl[i].busy) begin
        resolve(mdl[i].qj, mdl[i].vj, nxt[i].qj, nxt[i].vj);
        resolve(mdl[i].qk, mdl[i].vk, nxt[i].qk, nxt[i].vk);
      end
    end
    if (ready_l.size() > 0) begin
      m_en  = 1;
      m_op  = mdl[ready_l[0]].op;  m_rs1 = mdl[ready_l[0]].vj; m_rs2 = mdl[ready_l[0]].vk;
      m_imm = mdl[ready_l[0]].imm; m_pc  = mdl[ready_l[0]].pc; m_rob = mdl[ready_l[0]].rob;
      nxt[ready_l[0]].busy = 0;
    end
    if (issue_en && free_l.size() > 0) begin
      nxt[free_l[0]].busy = 1;
      nxt[free_l[0]].op   = issue_openum;
      nxt[free_l[0]].imm  = issue_imm;
      nxt[free_l[0]].pc   = issue_pc;
      nxt[free_l[0]].rob  = issue_rob_pos;
      resolve(issue_rs1_rob_pos, issue_rs1_val, nxt[free_l[0]].qj, nxt[free_l[0]].vj);
      resolve(issue_rs2_rob_pos, issue_rs2_val, nxt[free_l[0]].qk, nxt[free_l[0]].vk);
    end
    mdl = nxt;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1; rdy = 1; clr = 0; issue_en = 0;
    issue_openum = 0; issue_rs1_val = 0; issue_rs2_val = 0; issue_imm = 0; issue_pc = 0;
    issue_rs1_rob_pos = 0; issue_rs2_rob_pos = 0; issue_rob_pos = 0;
    alu_result_ready = 0; alu_result_rob_pos = 0; alu_result_val = 0;
    lsb_load_result_ready = 0; lsb_load_result_rob_pos = 0; lsb_load_result_val = 0;
  endtask

  task automatic set_issue(input bit [5:0] op, input bit [31:0] v1, input bit [4:0] t1,
                           input bit [31:0] v2, input bit [4:0] t2, input bit [4:0] rob);
    issue_en = 1; issue_openum = op;
    issue_rs1_val = v1; issue_rs1_rob_pos = t1;
    issue_rs2_val = v2; issue_rs2_rob_pos = t2;
    issue_imm = 32'h100 + 32'(rob); issue_pc = 32'h8000 + 32'(rob) * 4; issue_rob_pos = rob;
  endtask

  task automatic test_reset();
    idle(); rst = 0;
    tick(); tick();
    rst = 1;
    n_cmp++;
    if ({alu_en, rs_full} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: en/full=%b expected 00", {alu_en, rs_full});
    end
    n_cmp++;
    if ({alu_openum, alu_rs1_val, alu_rs2_val, alu_imm, alu_pc, alu_rob_pos} !== '0) begin
      n_fail++; $display("FAIL reset_data: op=%0d rob=%0d rs1=%h expected all zero",
                         alu_openum, alu_rob_pos, alu_rs1_val);
    end
  endtask

  task automatic test_ready_issue();
    set_issue(6'd1, 32'd3, 5'd0, 32'd4, 5'd0, 5'd2);
    tick();
    idle();
    n_cmp++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL ready_early: en=%b expected 0", alu_en); end
    tick();
    n_cmp++;
    if ({alu_en, alu_openum, alu_rs1_val, alu_rs2_val, alu_rob_pos} !==
        {1'b1, 6'd1, 32'd3, 32'd4, 5'd2}) begin
      n_fail++; $display("FAIL ready_dispatch: en=%b op=%0d rs1=%0d rs2=%0d rob=%0d expected 1/1/3/4/2",
                         alu_en, alu_openum, alu_rs1_val, alu_rs2_val, alu_rob_pos);
    end
    n_cmp++;
    if ({alu_imm, alu_pc} !== {32'h102, 32'h8008}) begin
      n_fail++; $display("FAIL ready_imm_pc: imm=%h pc=%h expected 102/8008", alu_imm, alu_pc);
    end
    tick();
    n_cmp++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL ready_single: en=%b expected 0", alu_en); end
  endtask

  task automatic test_wakeup();
    set_issue(6'd2, 32'hDEAD, 5'd5, 32'd9, 5'd0, 5'd3);
    tick();
    idle(); tick();
    n_cmp++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL wakeup_blocked: en=%b expected 0", alu_en); end
    alu_result_ready = 1; alu_result_rob_pos = 5; alu_result_val = 32'h10;
    tick();
    idle();
    n_cmp++;
    if (alu_en !== 1'b0) begin n_fail++; $display("FAIL wakeup_early: en=%b expected 0", alu_en); end
    tick();
    n_cmp++;
    if ({alu_en, alu_rs1_val, alu_rs2_val, alu_rob_pos} !== {1'b1, 32'h10, 32'd9, 5'd3}) begin
      n_fail++; $display("FAIL wakeup_dispatch: en=%b rs1=%h rs2=%h rob=%0d expected 1/10/9/3",
                         alu_en, alu_rs1_val, alu_rs2_val, alu_rob_pos);
    end
    tick();
  endtask

  task automatic test_forward();
    set_issue(6'd3, 32'd1, 5'd0, 32'hFFFF, 5'd7, 5'd4);
    lsb_load_result_ready = 1; lsb_load_result_rob_pos = 7; lsb_load_result_val = 32'hAB;
    tick();
    idle(); tick();
    n_cmp++;
    if ({alu_en, alu_rs2_val, alu_rob_pos} !== {1'b1, 32'hAB, 5'd4}) begin
      n_fail++; $display("FAIL forward: en=%b rs2=%h rob=%0d expected 1/ab/4",
                         alu_en, alu_rs2_val, alu_rob_pos);
    end
    tick();
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 7; k++) begin
      set_issue(6'd4, 32'd0, 5'd9, 32'(k), 5'd0, 5'(k));
      tick();
      n_cmp++;
      if (rs_full !== (k == 7)) begin
        n_fail++; $display("FAIL fill_full_%0d: full=%b expected %b", k, rs_full, k == 7);
      end
    end
    set_issue(6'd4, 32'd0, 5'd9, 32'd8, 5'd0, 5'd8);
    tick();
    set_issue(6'd5, 32'd1, 5'd0, 32'd2, 5'd0, 5'd10);
    tick();
    idle();
    n_cmp++;
    if ({alu_en, rs_full} !== 2'b01) begin
      n_fail++; $display("FAIL fill_ninth: en/full=%b expected 01", {alu_en, rs_full});
    end
    alu_result_ready = 1; alu_result_rob_pos = 9; alu_result_val = 32'h99;
    tick();
    idle();
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if ({alu_en, alu_rob_pos, alu_rs1_val, alu_rs2_val} !== {1'b1, 5'(k), 32'h99, 32'(k)}) begin
        n_fail++; $display("FAIL fill_order_%0d: en=%b rob=%0d rs1=%h rs2=%0d expected 1/%0d/99/%0d",
                           k, alu_en, alu_rob_pos, alu_rs1_val, alu_rs2_val, k, k);
      end
    end
    tick();
    n_cmp++;
    if ({alu_en, rs_full} !== 2'b00) begin
      n_fail++; $display("FAIL fill_drained: en/full=%b expected 00", {alu_en, rs_full});
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      set_issue(6'd6, 32'd0, 5'd12, 32'd0, 5'd0, 5'(20 + k));
      tick();
    end
    set_issue(6'd7, 32'd5, 5'd0, 32'd6, 5'd0, 5'd25);
    clr = 1;
    tick();
    idle();
    n_cmp++;
    if ({alu_en, rs_full} !== 2'b00) begin
      n_fail++; $display("FAIL flush_state: en/full=%b expected 00", {alu_en, rs_full});
    end
    alu_result_ready = 1; alu_result_rob_pos = 12; alu_result_val = 32'h55;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (alu_en !== 1'b0) begin
        n_fail++; $display("FAIL flush_no_dispatch_%0d: en=%b expected 0", k, alu_en);
      end
    end
  endtask

  task automatic test_stall();
    set_issue(6'd8, 32'd11, 5'd0, 32'd12, 5'd0, 5'd4);
    tick();
    idle(); rdy = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (alu_en !== 1'b0) begin n_fail++; $display("FAIL stall_%0d: en=%b expected 0", k, alu_en); end
    end
    rdy = 1;
    tick();
    n_cmp++;
    if ({alu_en, alu_rob_pos, alu_rs1_val} !== {1'b1, 5'd4, 32'd11}) begin
      n_fail++; $display("FAIL stall_resume: en=%b rob=%0d rs1=%0d expected 1/4/11",
                         alu_en, alu_rob_pos, alu_rs1_val);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_issue(6'd9, 32'd1, 5'd0, 32'd2, 5'd0, 5'd6);
    tick();
    set_issue(6'd9, 32'd0, 5'd15, 32'd2, 5'd0, 5'd7);
    tick();
    idle(); rst = 0;
    tick();
    rst = 1;
    n_cmp++;
    if ({alu_en, rs_full, alu_rob_pos, alu_rs1_val} !== {2'b00, 5'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_mid: en=%b full=%b rob=%0d rs1=%0d expected 0/0/0/0",
                         alu_en, rs_full, alu_rob_pos, alu_rs1_val);
    end
    alu_result_ready = 1; alu_result_rob_pos = 15; alu_result_val = 32'h77;
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (alu_en !== 1'b0) begin
        n_fail++; $display("FAIL reset_empty_%0d: en=%b expected 0", k, alu_en);
      end
    end
  endtask

  function automatic bit [4:0] rand_tag();
    return ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      idle();
      rst = ($urandom_range(0, 199) != 0);
      clr = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1)
        set_issue(6'($urandom), $urandom, rand_tag(), $urandom, rand_tag(), 5'($urandom));
      alu_result_ready      = ($urandom_range(0, 2) == 0);
      alu_result_rob_pos    = 5'($urandom_range(1, 6));
      alu_result_val        = $urandom;
      lsb_load_result_ready = ($urandom_range(0, 2) == 0);
      lsb_load_result_rob_pos = (alu_result_rob_pos % 6) + 1;
      lsb_load_result_val   = $urandom;
      tick();
      n_cmp++;
      if ({alu_en, rs_full} !== {m_en, model_free() <= 1}) begin
        n_fail++; $display("FAIL rand_flags_c%0d: en/full=%b%b expected %b%b",
                           c, alu_en, rs_full, m_en, model_free() <= 1);
      end
      if (m_en) begin
        n_cmp++;
        if ({alu_openum, alu_rs1_val, alu_rs2_val, alu_imm, alu_pc, alu_rob_pos} !==
            {m_op, m_rs1, m_rs2, m_imm, m_pc, m_rob}) begin
          n_fail++; $display("FAIL rand_data_c%0d: op=%0d rs1=%h rs2=%h rob=%0d expected %0d/%h/%h/%0d",
                             c, alu_openum, alu_rs1_val, alu_rs2_val, alu_rob_pos,
                             m_op, m_rs1, m_rs2, m_rob);
        end
      end
    end
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = '{default: 0};
    m_en = 0;
    idle();
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_forward();
    test_fill();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
